// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and feeds the IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch_cnt and bubble_cnt outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic [31:0] id_pc4
);

  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        accept;
  logic        load;
  logic [31:0] pc_plus4;

  assign accept   = req_q && imem_ack;
  assign pc_plus4 = addr_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    drop_d       = drop_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pc4_d   = skid_pc4_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    load         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = WAIT;
      end
      WAIT: begin
        if (accept) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = run ? WAIT : IDLE;
          end else if (!id_valid_q || !stall) begin
            load       = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = addr_q;
            id_pc4_d   = pc_plus4;
            pc_d       = pc_plus4;
            state_d    = run ? WAIT : IDLE;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = addr_q;
            skid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = FULL;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      FULL: begin
        if (redirect) begin
          state_d = run ? WAIT : IDLE;
        end else if (!stall) begin
          load       = 1'b1;
          id_instr_d = skid_instr_q;
          id_pc_d    = skid_pc_q;
          id_pc4_d   = skid_pc4_q;
          state_d    = run ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load)        id_valid_d = 1'b1;
    else if (!stall) id_valid_d = 1'b0;

    if (redirect) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
    end

    // A request still waiting for its ack keeps its address; a fresh one takes the latest pc.
    if (state_d == WAIT && !(state_q == WAIT && !accept)) addr_d = pc_d;
    req_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      drop_q       <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= '0;
      id_pc4_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      drop_q       <= drop_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc4_q   <= skid_pc4_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, load};
    bubble_cnt_d = bubble_cnt_q + {31'd0, (run && !stall && !id_valid_q)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a latency-programmable instruction memory model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  int wcnt     = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .run(run), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt),
`endif
    .id_pc4(id_pc4)
  );

  always #5 clk = ~clk;

  // Memory acks after `lat` idle cycles of an asserted request.
  assign imem_ack   = imem_req && (wcnt == lat);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc",    id_pc,    32'h0);
    chk("rst_pc4",   id_pc4,   32'h0);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    rst = 1'b0; run = 1'b1; lat = 0;

    // zero-wait streaming
    step();                                          // T1
    chk("t1_req",   {31'd0, imem_req}, 32'd1);
    chk("t1_addr",  imem_addr, 32'h0);
    chk("t1_valid", {31'd0, id_valid}, 32'd0);
    step();                                          // T2
    chk("t2_valid", {31'd0, id_valid}, 32'd1);
    chk("t2_pc",    id_pc,    32'h0);
    chk("t2_instr", id_instr, 32'hA5A5_0000);
    chk("t2_pc4",   id_pc4,   32'h4);
    step();                                          // T3
    chk("t3_pc",    id_pc,    32'h4);
    chk("t3_instr", id_instr, 32'hA5A5_0004);
    step();                                          // T4
    chk("t4_pc",    id_pc,    32'h8);
    step();                                          // T5 = T0 of delayed phase
    chk("t5_pc",    id_pc,    32'hC);
    chk("t5_pc4",   id_pc4,   32'h10);
    chk("t5_addr",  imem_addr, 32'h10);

    // three-cycle ack latency
    lat = 3;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("lat_addr",  imem_addr, 32'h10);
      chk("lat_valid", {31'd0, id_valid}, 32'd0);
    end
    step();
    chk("lat_v1", {31'd0, id_valid}, 32'd1);
    chk("lat_p1", id_pc, 32'h10);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("lat_bubble", {31'd0, id_valid}, 32'd0);
      chk("lat_addr2",  imem_addr, 32'h14);
    end
    step();                                          // T8
    chk("lat_v2", {31'd0, id_valid}, 32'd1);
    chk("lat_p2", id_pc, 32'h14);

    // stall with skid
    stall = 1'b1; lat = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("stall_req",   {31'd0, imem_req}, 32'd0);
      chk("stall_pc",    id_pc, 32'h14);
      chk("stall_valid", {31'd0, id_valid}, 32'd1);
    end
    stall = 1'b0;
    step();                                          // T12
    chk("skid_pc",    id_pc,    32'h18);
    chk("skid_instr", id_instr, 32'hA5A5_0018);
    chk("skid_addr",  imem_addr, 32'h1C);
    step();                                          // T13
    chk("after_pc",   id_pc, 32'h1C);
    chk("after_addr", imem_addr, 32'h20);

    // redirect with an outstanding request
    lat = 3;
    step();                                          // T14
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();                                          // T15
    redirect = 1'b0;
    chk("drop_addr1", imem_addr, 32'h20);
    chk("drop_valid", {31'd0, id_valid}, 32'd0);
    step();                                          // T16 (ack of 0x20, discarded)
    chk("drop_addr2", imem_addr, 32'h20);
    step();                                          // T17
    chk("rd_addr",  imem_addr, 32'h100);
    chk("rd_req",   {31'd0, imem_req}, 32'd1);
    chk("rd_valid", {31'd0, id_valid}, 32'd0);
    step(); step(); step();                          // T20
    chk("rd_valid2", {31'd0, id_valid}, 32'd0);
    step();                                          // T21
    chk("rd_v",     {31'd0, id_valid}, 32'd1);
    chk("rd_pc",    id_pc,    32'h100);
    chk("rd_instr", id_instr, 32'hA5A5_0100);

    // redirect coinciding with ack under stall
    lat = 0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();                                          // T22
    redirect = 1'b0;
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_addr",  imem_addr, 32'h200);
    chk("flush_req",   {31'd0, imem_req}, 32'd1);
    step();                                          // T23
    chk("flush_v", {31'd0, id_valid}, 32'd1);
    chk("flush_pc", id_pc, 32'h200);
    step();                                          // T24 (0x204 parked in skid)
    chk("full_req", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();                                          // T25
    redirect = 1'b0; stall = 1'b0;
    chk("fullrd_valid", {31'd0, id_valid}, 32'd0);
    chk("fullrd_addr",  imem_addr, 32'h300);
    step();                                          // T26
    chk("fullrd_pc", id_pc, 32'h300);

    // PC wrap, then run drop mid-wait
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();                                          // T27
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();                                          // T28
    chk("wrap_pc",   id_pc,  32'hFFFF_FFFC);
    chk("wrap_pc4",  id_pc4, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);
    lat = 3;
    step();                                          // T29
    run = 1'b0;
    step();                                          // T30
    chk("stop_req", {31'd0, imem_req}, 32'd1);
    step();                                          // T31 (ack)
    step();                                          // T32
    chk("stop_v",    {31'd0, id_valid}, 32'd1);
    chk("stop_pc",   id_pc, 32'h0);
    chk("stop_req2", {31'd0, imem_req}, 32'd0);
    step();                                          // T33
    chk("stop_req3",   {31'd0, imem_req}, 32'd0);
    chk("stop_bubble", {31'd0, id_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
